// File: rtl/sd_downsize.sv
// Width downsizer for the srdy/drdy closure pipeline: each accepted word is
// emitted as `ratio` narrower beats, with a one-word staging buffer for full throughput.
module sd_downsize #(
  parameter int width     = 16,
  parameter int ratio     = 2,
  parameter bit lsb_first = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     c_srdy,
  output logic                     c_drdy,
  input  logic [width-1:0]         c_data,
  output logic                     p_srdy,
  input  logic                     p_drdy,
  output logic [width/ratio-1:0]   p_data,
  output logic                     p_first,
  output logic                     p_last
);

  localparam int owidth = width / ratio;
  localparam int cw     = (ratio > 2) ? $clog2(ratio) : 1;
  localparam logic [cw-1:0] last_idx = cw'(ratio - 1);

  logic [width-1:0] hold_q, hold_d;
  logic [width-1:0] next_q, next_d;
  logic             hold_valid_q, hold_valid_d;
  logic             next_valid_q, next_valid_d;
  logic [cw-1:0]    cnt_q, cnt_d;
  logic             c_drdy_q, c_drdy_d;

  logic acc, pxf, lastx, hold_free;

  always_comb begin
    acc       = c_srdy & c_drdy_q;
    pxf       = hold_valid_q & p_drdy;
    lastx     = pxf & (cnt_q == last_idx);
    hold_free = !hold_valid_q | lastx;

    // NOTE: every next-state value gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    hold_d       = hold_q;
    next_d       = next_q;
    hold_valid_d = hold_valid_q;
    next_valid_d = next_valid_q;
    cnt_d        = cnt_q;

    if (hold_free) begin
      cnt_d = '0;
      if (next_valid_q) begin
        hold_d       = next_q;
        hold_valid_d = 1'b1;
        if (acc) next_d = c_data;
        else     next_valid_d = 1'b0;
      end else if (acc) begin
        hold_d       = c_data;
        hold_valid_d = 1'b1;
      end else begin
        hold_valid_d = 1'b0;
      end
    end else begin
      if (acc) begin
        next_d       = c_data;
        next_valid_d = 1'b1;
      end
      if (pxf) cnt_d = cnt_q + cw'(1);
    end

    // Ready is registered from the staging buffer's next state, so neither
    // p_drdy nor c_srdy reaches c_drdy combinationally.
    c_drdy_d = !next_valid_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      next_valid_q <= 1'b0;
      cnt_q        <= '0;
      c_drdy_q     <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      next_valid_q <= next_valid_d;
      cnt_q        <= cnt_d;
      c_drdy_q     <= c_drdy_d;
    end
  end

  // NOTE: data registers carry no reset; their contents are qualified by the
  // valid flags, so resetting them would only cost reset routing.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    next_q <= next_d;
  end

  logic [owidth-1:0] slices [ratio];
  logic [cw-1:0]     sel;

  always_comb begin
    for (int i = 0; i < ratio; i++) slices[i] = hold_q[i*owidth +: owidth];
    sel = lsb_first ? cnt_q : (last_idx - cnt_q);
  end

  assign p_data  = slices[sel];
  assign p_srdy  = hold_valid_q;
  assign c_drdy  = c_drdy_q;
  assign p_first = (cnt_q == '0);
  assign p_last  = (cnt_q == last_idx);

endmodule
